regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register busy scoreboard and pending count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports and a0.
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic                            we,
  input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]        issue_addr,
  output logic [ADDRESS_WIDTH:0]          pending,
  output logic [DATA_WIDTH-1:0]           a0
);

  localparam int NREG = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

  logic [DATA_WIDTH-1:0]  r_regs [NREG];
  logic [NREG-1:0]        r_busy;
  logic [ADDRESS_WIDTH:0] r_pending;

  logic w_wr_hit;
  logic w_iss_hit;
  logic w_inc;
  logic w_dec;

  assign w_wr_hit  = we && (wr_addr != '0);
  assign w_iss_hit = issue_valid && (issue_addr != '0);
  // A colliding issue keeps the register busy, so its writeback does not retire it.
  assign w_inc = w_iss_hit && !r_busy[issue_addr];
  assign w_dec = w_wr_hit && r_busy[wr_addr] && !(w_iss_hit && (issue_addr == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      if (w_wr_hit) begin
        r_regs[wr_addr] <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_iss_hit) begin
        r_busy[issue_addr] <= 1'b1;
      end
      case ({w_inc, w_dec})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign pending = r_pending;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] w_addr;
    assign w_addr = rd_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = w_wr_hit && (w_addr == wr_addr);
    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = w_fwd ? wr_data : r_regs[w_addr];
    assign rd_busy[g] = w_fwd ? (w_iss_hit && (issue_addr == w_addr)) : r_busy[w_addr];
`else
    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_addr];
    assign rd_busy[g] = r_busy[w_addr];
`endif
  end

`ifdef REGFILE_BYPASS_EN
  assign a0 = (w_wr_hit && (wr_addr == A0_IDX)) ? wr_data : r_regs[A0_IDX];
`else
  assign a0 = r_regs[A0_IDX];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb with four read ports.
// Expectations are queued as stimulus is applied and drained against the DUT outputs.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_PEND = 2;
  localparam int K_A0   = 3;
  localparam int K_ALL  = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic [AW:0]       pending;
  logic [DW-1:0]     a0;

  int n_checks;
  int n_fail;

  typedef struct {
    string        tag;
    int           kind;
    int           port;
    logic [127:0] val;
  } exp_t;

  exp_t sbq[$];

  regfile_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .pending(pending), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void expect_item(input string tag, input int kind, input int port,
                                      input logic [127:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.val = val;
    sbq.push_back(e);
  endfunction

  task automatic drain();
    while (sbq.size() > 0) begin
      exp_t e;
      logic [127:0] got;
      e = sbq.pop_front();
      case (e.kind)
        K_DATA:  got = 128'(rd_data[e.port*DW +: DW]);
        K_BUSY:  got = 128'(rd_busy[e.port]);
        K_PEND:  got = 128'(pending);
        K_A0:    got = 128'(a0);
        default: got = rd_data;
      endcase
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
  endtask

  task automatic set_rd(input int p, input int addr);
    rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  task automatic write_reg(input int addr, input logic [DW-1:0] data);
    we = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tick();
    idle();
  endtask

  task automatic issue_reg(input int addr);
    issue_valid = 1'b1; issue_addr = AW'(addr);
    tick();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    set_rd(0, 5); set_rd(1, 10); set_rd(2, 31); set_rd(3, 0);
    #1;
    expect_item("rst_rd5", K_DATA, 0, 0);
    expect_item("rst_rd31", K_DATA, 2, 0);
    expect_item("rst_busy", K_BUSY, 2, 0);
    expect_item("rst_pend", K_PEND, 0, 0);
    expect_item("rst_a0", K_A0, 0, 0);
    drain();

    // mid-run reset clears data, busy, pending
    write_reg(5, 32'hDEADBEEF);
    write_reg(10, 32'h0BADF00D);
    issue_reg(6);
    expect_item("pre_rst_x5", K_DATA, 0, 32'hDEADBEEF);
    expect_item("pre_rst_a0", K_A0, 0, 32'h0BADF00D);
    expect_item("pre_rst_pend", K_PEND, 0, 1);
    drain();
    #2;
    rst = 1'b1;
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h77777777;
    issue_valid = 1'b1; issue_addr = 5'd9;
    #1;
    expect_item("async_rst_x5", K_DATA, 0, 0);
    expect_item("async_rst_pend", K_PEND, 0, 0);
    expect_item("async_rst_a0", K_A0, 0, 0);
    drain();
    tick();
    idle();
    rst = 1'b0;
    set_rd(1, 9);
    #1;
    expect_item("rst_discard_x5", K_DATA, 0, 0);
    expect_item("rst_discard_busy9", K_BUSY, 1, 0);
    expect_item("rst_discard_pend", K_PEND, 0, 0);
    drain();

    // x0 is immutable
    set_rd(0, 0);
    we = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_addr = '0;
    tick();
    idle();
    expect_item("x0_data", K_DATA, 0, 0);
    expect_item("x0_busy", K_BUSY, 0, 0);
    expect_item("x0_pend", K_PEND, 0, 0);
    drain();

    // scoreboard issue / writeback
    set_rd(0, 3);
    issue_reg(3);
    expect_item("sb_busy3", K_BUSY, 0, 1);
    expect_item("sb_pend1", K_PEND, 0, 1);
    drain();
    write_reg(3, 32'h1234);
    expect_item("sb_wb_busy3", K_BUSY, 0, 0);
    expect_item("sb_wb_pend0", K_PEND, 0, 0);
    expect_item("sb_wb_data3", K_DATA, 0, 32'h1234);
    drain();

    // issue+writeback collision: new producer wins
    set_rd(0, 7); set_rd(1, 9); set_rd(2, 8);
    issue_reg(7);
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    idle();
    expect_item("col_data7", K_DATA, 0, 32'h55);
    expect_item("col_busy7", K_BUSY, 0, 1);
    expect_item("col_pend", K_PEND, 0, 1);
    drain();

    issue_reg(7);
    expect_item("reissue_pend", K_PEND, 0, 1);
    drain();
    write_reg(9, 32'h99);
    expect_item("wb_idle_data9", K_DATA, 1, 32'h99);
    expect_item("wb_idle_pend", K_PEND, 0, 1);
    drain();

    // set x8 while clearing x7: net zero
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h70;
    issue_valid = 1'b1; issue_addr = 5'd8;
    tick();
    idle();
    expect_item("swap_busy7", K_BUSY, 0, 0);
    expect_item("swap_busy8", K_BUSY, 2, 1);
    expect_item("swap_pend", K_PEND, 0, 1);
    drain();
    write_reg(8, 32'h80);
    expect_item("clr8_pend", K_PEND, 0, 0);
    drain();

    // bypass (or pre-edge value) on x10
    write_reg(10, 32'h11111111);
    set_rd(1, 10);
    we = 1'b1; wr_addr = 5'd10; wr_data = 32'hA5A5A5A5;
    #1;
    expect_item("byp_rd10", K_DATA, 1, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    expect_item("byp_a0", K_A0, 0, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    drain();
    tick();
    idle();
    expect_item("post_rd10", K_DATA, 1, 32'hA5A5A5A5);
    expect_item("post_a0", K_A0, 0, 32'hA5A5A5A5);
    drain();

    we = 1'b1; wr_addr = 5'd10; wr_data = 32'h5A5A5A5A;
    issue_valid = 1'b1; issue_addr = 5'd10;
    #1;
    expect_item("byp_col_busy", K_BUSY, 1, BYP ? 1 : 0);
    expect_item("byp_col_data", K_DATA, 1, BYP ? 32'h5A5A5A5A : 32'hA5A5A5A5);
    drain();
    tick();
    idle();
    expect_item("col10_busy", K_BUSY, 1, 1);
    expect_item("col10_pend", K_PEND, 0, 1);
    drain();
    write_reg(10, 32'h10);
    expect_item("col10_clr_pend", K_PEND, 0, 0);
    drain();

    // fill every register: pending tops out at 31 without wrapping
    for (int i = 1; i < 32; i++) begin
      issue_reg(i);
    end
    expect_item("full_pend", K_PEND, 0, 31);
    drain();
    issue_reg(17);
    expect_item("full_reissue_pend", K_PEND, 0, 31);
    drain();
    for (int i = 1; i < 32; i++) begin
      write_reg(i, DW'(i * 16));
    end
    set_rd(0, 31);
    #1;
    expect_item("empty_pend", K_PEND, 0, 0);
    expect_item("empty_data31", K_DATA, 0, 31 * 16);
    drain();

    // all four ports at once
    for (int i = 1; i <= 4; i++) begin
      write_reg(i, DW'(i));
    end
    for (int p = 0; p < 4; p++) begin
      set_rd(p, p + 1);
    end
    #1;
    expect_item("multiport", K_ALL, 0, {32'd4, 32'd3, 32'd2, 32'd1});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
